// File: rtl/coeff_loader_pkg.sv
// Shared types and helpers for the coefficient loader.
package coeff_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ACK   = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    // Widest coefficient the extension helper can handle.
    localparam int unsigned MAX_COEFF_W = 256;

    // Number of input beats that make up one full-width coefficient.
    function automatic int unsigned calc_beats(input int unsigned coeff_w, input int unsigned in_w);
        return coeff_w / in_w;
    endfunction

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Extend the low in_w bits of data to the full width, by sign or by zero.
    function automatic logic [MAX_COEFF_W-1:0] extend_beat(
        input logic [MAX_COEFF_W-1:0] data,
        input int unsigned            in_w,
        input logic                   sign_ext
    );
        logic [MAX_COEFF_W-1:0] mask;
        logic                   fill;
        mask = ~({MAX_COEFF_W{1'b1}} << in_w);
        fill = sign_ext & (|(data & (MAX_COEFF_W'(1) << (in_w - 1))));
        return (data & mask) | (fill ? ~mask : '0);
    endfunction

endpackage

// File: rtl/coeff_loader_shadow.sv
// Shadow frame collector: assembles beats into coefficients and flags a full frame.
module coeff_shadow
    import coeff_loader_pkg::*;
#(
    parameter int unsigned NUM_COEFF = 2,
    parameter int unsigned COEFF_W   = 32,
    parameter int unsigned IN_W      = 8,
    parameter bit          SIGN_EXT  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_ena,
    input  logic                           i_flush,
    input  logic                           i_short_mode,
    input  logic                           i_in_valid,
    input  logic [IN_W-1:0]                i_in_data,
    input  logic                           i_commit,
    output logic                           o_in_ready,
    output logic                           o_frame_full,
    output logic [NUM_COEFF*COEFF_W-1:0]   o_shadow_flat
);

    localparam int unsigned BEATS       = calc_beats(COEFF_W, IN_W);
    localparam int unsigned BEAT_CNT_W  = cnt_width(BEATS);
    localparam int unsigned COEFF_CNT_W = cnt_width(NUM_COEFF);
    localparam logic [BEAT_CNT_W-1:0]  LAST_BEAT  = BEAT_CNT_W'(BEATS - 1);
    localparam logic [COEFF_CNT_W-1:0] LAST_COEFF = COEFF_CNT_W'(NUM_COEFF - 1);

    logic [BEAT_CNT_W-1:0]  r_beat;
    logic [COEFF_CNT_W-1:0] r_coeff;
    logic                   r_short;
    logic                   r_frame_full;
    logic [COEFF_W-1:0]     r_shadow [NUM_COEFF];

    logic                   w_accept;
    logic                   w_first;
    logic                   w_short;
    logic                   w_last_beat;
    logic                   w_last_coeff;
    logic [COEFF_W-1:0]     w_ext;
    logic [COEFF_W-1:0]     w_old;
    logic [COEFF_W-1:0]     w_mask;
    logic [COEFF_W-1:0]     w_word;
    logic [COEFF_W-1:0]     w_new;

    assign o_in_ready   = i_ena & ~r_frame_full & ~i_flush;
    assign o_frame_full = r_frame_full;
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_first      = (r_beat == '0) && (r_coeff == '0);
    // Mode is taken live on the first beat, from the latch afterwards.
    assign w_short      = w_first ? i_short_mode : r_short;
    assign w_last_beat  = w_short | (r_beat == LAST_BEAT);
    assign w_last_coeff = (r_coeff == LAST_COEFF);
    assign w_ext        = COEFF_W'(extend_beat(MAX_COEFF_W'(i_in_data), IN_W, SIGN_EXT));
    assign w_mask       = COEFF_W'({IN_W{1'b1}}) << (r_beat * IN_W);
    assign w_word       = COEFF_W'(i_in_data) << (r_beat * IN_W);

    // Select the entry being assembled and merge the incoming beat into it.
    always_comb begin
        w_old = '0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (r_coeff == COEFF_CNT_W'(i)) w_old = r_shadow[i];
            o_shadow_flat[i*COEFF_W +: COEFF_W] = r_shadow[i];
        end
        if (w_short)
            w_new = w_ext;
        else if (r_beat == '0)
            w_new = COEFF_W'(i_in_data);
        else
            w_new = (w_old & ~w_mask) | w_word;
    end

    // Beat/coeff counters, mode latch and frame-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat       <= '0;
            r_coeff      <= '0;
            r_short      <= 1'b0;
            r_frame_full <= 1'b0;
        end else if (i_ena) begin
            if (i_flush) begin
                r_beat       <= '0;
                r_coeff      <= '0;
                r_frame_full <= 1'b0;
            end else begin
                if (i_commit) r_frame_full <= 1'b0;
                if (w_accept) begin
                    if (w_first) r_short <= i_short_mode;
                    if (w_last_beat) begin
                        r_beat <= '0;
                        if (w_last_coeff) begin
                            r_coeff      <= '0;
                            r_frame_full <= 1'b1;
                        end else begin
                            r_coeff <= r_coeff + 1'b1;
                        end
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
            end
        end
    end

    // Shadow storage, written one entry per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFF; i++) r_shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COEFF; i++)
                if (w_accept && (r_coeff == COEFF_CNT_W'(i))) r_shadow[i] <= w_new;
        end
    end

endmodule

// File: rtl/coeff_loader.sv
// Coefficient loader top: commits shadow frames to the core and runs the start/busy handshake.
//
// state   | meaning
// S_IDLE  | waiting for a full shadow frame and an idle core
// S_START | coefficients committed, start_calc asserted this cycle
// S_ACK   | waiting for core_busy to rise, bounded by ACK_TIMEOUT
// S_RUN   | core busy; next frame may be collected meanwhile
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int unsigned NUM_COEFF   = 2,
    parameter int unsigned COEFF_W     = 32,
    parameter int unsigned IN_W        = 8,
    parameter bit          SIGN_EXT    = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_ena,
    input  logic                         i_flush,
    input  logic                         i_short_mode,
    input  logic                         i_in_valid,
    input  logic [IN_W-1:0]              i_in_data,
    output logic                         o_in_ready,
    output logic [NUM_COEFF*COEFF_W-1:0] o_coeff_flat,
    output logic                         o_start_calc,
    input  logic                         i_core_busy,
    output logic                         o_frame_full,
    output logic                         o_err_timeout
);

    localparam int unsigned ACK_CNT_W = cnt_width(ACK_TIMEOUT + 1);
    localparam logic [ACK_CNT_W-1:0] ACK_LIMIT = ACK_CNT_W'(ACK_TIMEOUT);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_idle_q;
    logic [ACK_CNT_W-1:0]           r_ack_cnt;
    logic                           r_err_timeout;
    logic [NUM_COEFF*COEFF_W-1:0]   r_coeff_flat;
    logic [NUM_COEFF*COEFF_W-1:0]   w_shadow_flat;
    logic                           w_frame_full;
    logic                           w_commit;
    logic                           w_start;
    logic                           w_ack_clr;
    logic                           w_ack_inc;
    logic                           w_timeout;

    coeff_shadow #(
        .NUM_COEFF (NUM_COEFF),
        .COEFF_W   (COEFF_W),
        .IN_W      (IN_W),
        .SIGN_EXT  (SIGN_EXT)
    ) u_shadow (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (i_ena),
        .i_flush       (i_flush),
        .i_short_mode  (i_short_mode),
        .i_in_valid    (i_in_valid),
        .i_in_data     (i_in_data),
        .i_commit      (w_commit),
        .o_in_ready    (o_in_ready),
        .o_frame_full  (w_frame_full),
        .o_shadow_flat (w_shadow_flat)
    );

    assign o_frame_full  = w_frame_full;
    assign o_coeff_flat  = r_coeff_flat;
    assign o_err_timeout = r_err_timeout;
    assign o_start_calc  = i_ena & w_start;

    // Next-state and handshake strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_start     = 1'b0;
        w_ack_clr   = 1'b0;
        w_ack_inc   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Core must have been idle for two consecutive samples.
                if (w_frame_full && r_idle_q && !i_core_busy) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start     = 1'b1;
                w_ack_clr   = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (i_core_busy) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_ack_inc = 1'b1;
                    if ((ACK_TIMEOUT != 0) && (r_ack_cnt + 1'b1 == ACK_LIMIT)) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (!i_core_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, idle filter, ack counter, commit register and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idle_q      <= 1'b0;
            r_ack_cnt     <= '0;
            r_err_timeout <= 1'b0;
            r_coeff_flat  <= '0;
        end else if (i_ena) begin
            r_state  <= w_state_nxt;
            r_idle_q <= ~i_core_busy;
            if (w_ack_clr)
                r_ack_cnt <= '0;
            else if (w_ack_inc)
                r_ack_cnt <= r_ack_cnt + 1'b1;
            if (w_commit) r_coeff_flat <= w_shadow_flat;
            // Flush is the software clear and takes priority over a new timeout.
            if (i_flush)
                r_err_timeout <= 1'b0;
            else if (w_timeout)
                r_err_timeout <= 1'b1;
        end
    end

endmodule
